// File: rtl/mem_req_initiator.sv
// mem_req_initiator: sequences tagged load/store requests onto a single-cycle
// byte-addressable memory port and returns tagged responses.
// Ports:
//   clk, rst                      - clock, async active-low reset
//   req_valid/req_ready           - request handshake (req_wr, req_addr, req_wdata, req_tag)
//   rsp_valid/rsp_ready           - response handshake (rsp_wr, rsp_rdata, rsp_tag)
//   mem_rst                       - active-high memory reset, held during INIT
//   mem_enable/mem_wr/mem_addr    - memory strobes and address, live only in ACCESS
//   mem_data_in/mem_data_out      - memory write / combinational read data
module mem_req_initiator #(
  parameter int unsigned TAG_W       = 3,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [7:0]       req_addr,
  input  logic [7:0]       req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic [7:0]       rsp_rdata,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             mem_rst,
  output logic             mem_enable,
  output logic             mem_wr,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_data_in,
  input  logic [7:0]       mem_data_out
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lat_wr, lat_wr_nxt;
  logic [TAG_W-1:0] lat_tag, lat_tag_nxt;

  logic             req_ready_nxt;
  logic             rsp_valid_nxt;
  logic             rsp_wr_nxt;
  logic [7:0]       rsp_rdata_nxt;
  logic [TAG_W-1:0] rsp_tag_nxt;
  logic             mem_rst_nxt;
  logic             mem_enable_nxt;
  logic             mem_wr_nxt;
  logic [7:0]       mem_addr_nxt;
  logic [7:0]       mem_data_in_nxt;

  // Next-state and next-output decode; every output is registered from here.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    lat_wr_nxt      = lat_wr;
    lat_tag_nxt     = lat_tag;
    req_ready_nxt   = 1'b0;
    rsp_valid_nxt   = rsp_valid;
    rsp_wr_nxt      = rsp_wr;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_tag_nxt     = rsp_tag;
    mem_rst_nxt     = 1'b0;
    // Memory strobes default low so they are only ever high for the ACCESS cycle.
    mem_enable_nxt  = 1'b0;
    mem_wr_nxt      = 1'b0;
    mem_addr_nxt    = 8'h00;
    mem_data_in_nxt = 8'h00;

    case (state)
      S_INIT: begin
        if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
          state_nxt     = S_IDLE;
          req_ready_nxt = 1'b1;
        end else begin
          cnt_nxt     = cnt + CNT_W'(1);
          mem_rst_nxt = 1'b1;
        end
      end
      S_IDLE: begin
        req_ready_nxt = 1'b1;
        if (req_valid && req_ready) begin
          state_nxt       = S_ACCESS;
          req_ready_nxt   = 1'b0;
          lat_wr_nxt      = req_wr;
          lat_tag_nxt     = req_tag;
          mem_enable_nxt  = 1'b1;
          mem_wr_nxt      = req_wr;
          mem_addr_nxt    = req_addr;
          mem_data_in_nxt = req_wr ? req_wdata : 8'h00;
        end
      end
      S_ACCESS: begin
        // Closing edge of the access: read data is sampled / write commits.
        state_nxt     = S_RESP;
        rsp_valid_nxt = 1'b1;
        rsp_wr_nxt    = lat_wr;
        rsp_tag_nxt   = lat_tag;
        rsp_rdata_nxt = lat_wr ? 8'h00 : mem_data_out;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_INIT;
      cnt         <= '0;
      lat_wr      <= 1'b0;
      lat_tag     <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_tag     <= '0;
      mem_rst     <= 1'b1;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= 8'h00;
      mem_data_in <= 8'h00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      lat_wr      <= lat_wr_nxt;
      lat_tag     <= lat_tag_nxt;
      req_ready   <= req_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_wr      <= rsp_wr_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_tag     <= rsp_tag_nxt;
      mem_rst     <= mem_rst_nxt;
      mem_enable  <= mem_enable_nxt;
      mem_wr      <= mem_wr_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_data_in <= mem_data_in_nxt;
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Testbench for mem_req_initiator: behavioural 256-byte memory, scoreboard of
// expected memory accesses and responses, plus directed timing checks.
module tb_mem_req_initiator;

  localparam int unsigned TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [7:0]       req_addr;
  logic [7:0]       req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_wr;
  logic [7:0]       rsp_rdata;
  logic [TAG_W-1:0] rsp_tag;
  logic             mem_rst;
  logic             mem_enable;
  logic             mem_wr;
  logic [7:0]       mem_addr;
  logic [7:0]       mem_data_in;
  logic [7:0]       mem_data_out;

  mem_req_initiator #(.TAG_W(TAG_W), .INIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
    .mem_rst(mem_rst), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, write on rising edge.
  logic [7:0] mem_model [256];
  logic [7:0] ref_mem   [256];
  assign mem_data_out = mem_model[mem_addr];
  always @(posedge clk) if (mem_enable && mem_wr) mem_model[mem_addr] <= mem_data_in;

  logic [16:0] exp_acc [$];   // {wr, addr, data_in}
  logic [11:0] exp_rsp [$];   // {wr, rdata, tag}
  int          acc_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request; push expectations at acceptance.
  task automatic send(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [TAG_W-1:0] tag, input bit drop);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_tag   = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("req_accept", 32'(req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    exp_acc.push_back({wr, addr, wr ? wdata : 8'h00});
    exp_rsp.push_back({wr, wr ? 8'h00 : ref_mem[addr], tag});
    if (wr) ref_mem[addr] = wdata;
    acc_cyc.push_back(cyc);
    @(posedge clk); #1;
    if (drop) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_acc.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_rsp.size() + exp_acc.size()), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: memory port contents, response contents and backpressure stability.
  logic        hold;
  logic [11:0] hold_val;
  initial hold = 1'b0;

  always @(negedge clk) begin
    logic [16:0] ea;
    logic [11:0] er;
    if (mem_enable) begin
      if (exp_acc.size() == 0) check("acc_unexpected", 32'(mem_enable), 0);
      else begin
        ea = exp_acc.pop_front();
        check("acc", 32'({mem_wr, mem_addr, mem_data_in}), 32'(ea));
      end
    end else begin
      check("mem_idle", 32'({mem_wr, mem_addr, mem_data_in}), 0);
    end
    if (hold && rst) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_stable", 32'({rsp_wr, rsp_rdata, rsp_tag}), 32'(hold_val));
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        er = exp_rsp.pop_front();
        check("rsp", 32'({rsp_wr, rsp_rdata, rsp_tag}), 32'(er));
      end
    end
    hold     = rsp_valid && !rsp_ready && rst;
    hold_val = {rsp_wr, rsp_rdata, rsp_tag};
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_mem_rst"}, 32'(mem_rst), 1);
    check({tag, "_mem_port"}, 32'({mem_enable, mem_wr, mem_addr, mem_data_in}), 0);
  endtask

  task automatic check_init_release(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    check({tag, "_e1_mem_rst"}, 32'(mem_rst), 1);
    check({tag, "_e1_req_ready"}, 32'(req_ready), 0);
    @(posedge clk); #1;
    check({tag, "_e2_mem_rst"}, 32'(mem_rst), 0);
    check({tag, "_e2_req_ready"}, 32'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_model[i] = 8'h00;
      ref_mem[i]   = 8'h00;
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    req_tag   = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_rsp_fields", 32'({rsp_wr, rsp_rdata, rsp_tag}), 0);
    check_init_release("init");

    // Store 0x10 <- 0xA5, tag 3.
    send(1'b1, 8'h10, 8'hA5, 3'd3, 1'b1);
    drain();

    // Load 0x10, tag 5, with latency checks.
    rsp_ready = 1'b0;
    send(1'b0, 8'h10, 8'h00, 3'd5, 1'b1);
    check("ld_k1_mem_enable", 32'(mem_enable), 1);
    check("ld_k1_mem_wr", 32'(mem_wr), 0);
    check("ld_k1_rsp_valid", 32'(rsp_valid), 0);
    check("ld_k1_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    check("ld_k2_rsp_valid", 32'(rsp_valid), 1);
    check("ld_k2_mem_enable", 32'(mem_enable), 0);
    rsp_ready = 1'b1;
    drain();

    // Backpressure on a load of 0xFF returning 0x3C.
    send(1'b1, 8'hFF, 8'h3C, 3'd1, 1'b1);
    drain();
    rsp_ready = 1'b0;
    send(1'b0, 8'hFF, 8'h00, 3'd6, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_rsp_valid_hi", 32'(rsp_valid), 1);
      check("bp_rdata", 32'(rsp_rdata), 32'h3C);
      check("bp_mem_enable", 32'(mem_enable), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_rsp_valid", 32'(rsp_valid), 0);
    check("bp_after_req_ready", 32'(req_ready), 1);
    drain();

    // Back-to-back with req_valid held: stores to 0x40+i, loads read them back.
    acc_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) send(1'b1, 8'(8'h40 + i), 8'(8'h5A ^ i), 3'(i), 1'b0);
      else            send(1'b0, 8'(8'h40 + i - 1), 8'h00, 3'(i), i == 5);
    end
    for (int i = 1; i < 6; i++) check("b2b_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 3);
    drain();

    // Reset during the ACCESS cycle of a store: aborted, no response.
    send(1'b1, 8'h20, 8'h77, 3'd2, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid");
    exp_acc.delete();
    exp_rsp.delete();
    ref_mem[8'h20] = 8'h00;
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_rsp_valid_low", 32'(rsp_valid), 0);
    end
    check_init_release("reinit");
    send(1'b0, 8'h20, 8'h00, 3'd7, 1'b1);
    send(1'b0, 8'h10, 8'h00, 3'd4, 1'b1);
    send(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
